icache_loader: RTL and testbench



---
 rtl/monociclo_pkg.sv | 23 ++
 rtl/icache_loader_byte_packer.sv | 49 ++++
 rtl/icache_loader.sv | 120 ++++++++++++
 tb/tb_icache_loader.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/monociclo_pkg.sv
// Shared definitions for the single-cycle core's instruction-cache path:
// cache geometry, loader state encoding and the image start byte.
package monociclo_pkg;

    localparam int CACHE_ADDR_W = 8;
    localparam int CACHE_DATA_W = 32;
    localparam logic [7:0] SYNC_BYTE = 8'h55;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_COUNT = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } loader_state_e;

    function automatic logic state_is_busy(loader_state_e s);
        return (s == ST_COUNT) || (s == ST_DATA) || (s == ST_WRITE) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/icache_loader_byte_packer.sv
// Packs incoming bytes little-endian into a 32-bit word and keeps a running
// XOR of every byte loaded since the last clear.
module byte_packer (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_full_o,
    output logic [7:0]  checksum_o
);

    logic [31:0] word_q, word_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [7:0]  chk_q, chk_d;

    always_comb begin
        word_d = word_q;
        cnt_d  = cnt_q;
        chk_d  = chk_q;
        if (clear_i) begin
            cnt_d = 2'd0;
            chk_d = 8'h00;
        end else if (load_i) begin
            word_d[cnt_q*8 +: 8] = byte_i;
            cnt_d                = cnt_q + 2'd1;
            chk_d                = chk_q ^ byte_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q <= 32'h0;
            cnt_q  <= 2'd0;
            chk_q  <= 8'h00;
        end else begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            chk_q  <= chk_d;
        end
    end

    // Asserted alongside the load of lane 3, so the FSM can leave DATA on that byte.
    assign word_full_o = load_i && (cnt_q == 2'd3);
    assign word_o      = word_q;
    assign checksum_o  = chk_q;

endmodule

// File: rtl/icache_loader.sv
// Receives a SYNC-framed program image over a byte handshake, writes it into
// the instruction cache from address 0, verifies the XOR checksum, releases the core.
//
// state | meaning
// IDLE  | waiting for SYNC, other bytes dropped
// COUNT | next byte is the last word index
// DATA  | collecting 4 bytes of the current word
// WRITE | one-cycle cache write, rx stalled
// CHECK | next byte is compared with the XOR checksum
// DONE  | image good, core released; SYNC reloads
// ERR   | checksum bad, core held; SYNC reloads
module icache_loader
    import monociclo_pkg::*;
#(
    parameter int         ADDR_W = CACHE_ADDR_W,
    parameter int         DATA_W = CACHE_DATA_W,
    parameter logic [7:0] SYNC   = SYNC_BYTE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        rx_data_i,
    input  logic              rx_valid_i,
    output logic              rx_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              cpu_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    loader_state_e     state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] last_q, last_d;

    logic        accept;
    logic        pk_clear;
    logic        pk_load;
    logic [31:0] pk_word;
    logic        pk_full;
    logic [7:0]  pk_chk;

    byte_packer u_packer (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (pk_clear),
        .load_i      (pk_load),
        .byte_i      (rx_data_i),
        .word_o      (pk_word),
        .word_full_o (pk_full),
        .checksum_o  (pk_chk)
    );

    assign accept = rx_valid_i && rx_ready_o;

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        last_d   = last_q;
        pk_clear = 1'b0;
        pk_load  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (accept && (rx_data_i == SYNC)) begin
                    state_d  = ST_COUNT;
                    index_d  = '0;
                    pk_clear = 1'b1;
                end
            end
            ST_COUNT: begin
                if (accept) begin
                    last_d  = ADDR_W'(rx_data_i);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pk_load = 1'b1;
                    if (pk_full) state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                // Compare before incrementing so a 256-word image never wraps index.
                if (index_q == last_q) begin
                    state_d = ST_CHECK;
                end else begin
                    index_d = index_q + 1'b1;
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept) state_d = (rx_data_i == pk_chk) ? ST_DONE : ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            index_q <= '0;
            last_q  <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            last_q  <= last_d;
        end
    end

    assign rx_ready_o = (state_q != ST_WRITE);
    assign wr_en_o    = (state_q == ST_WRITE);
    assign wr_addr_o  = index_q;
    assign wr_data_o  = DATA_W'(pk_word);
    assign busy_o     = state_is_busy(state_q);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = (state_q == ST_ERR);
    assign cpu_rst_no = (state_q == ST_DONE);

endmodule

// File: tb/tb_icache_loader.sv
// Self-checking bench for icache_loader: table-driven images with random
// payloads plus hand-written corner sequences.
module tb_icache_loader;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready_o;
    logic        wr_en_o;
    logic [7:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic        cpu_rst_no;
    logic        busy_o;
    logic        done_o;
    logic        err_o;

    icache_loader dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .rx_data_i  (rx_data),
        .rx_valid_i (rx_valid),
        .rx_ready_o (rx_ready_o),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .cpu_rst_no (cpu_rst_no),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int ready_low_cnt = 0;
    logic [39:0] exp_q[$];
    logic [7:0]  data_q[$];

    typedef struct {
        int c;
        bit hold;
        bit bad;
        int garbage;
        bit exp_done;
        bit exp_err;
    } vec_t;
    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Every write must be the next one the model expects; rx stalls only on writes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (!rx_ready_o) ready_low_cnt++;
            tests++;
            if (rx_ready_o == wr_en_o) begin
                fails++;
                $display("FAIL ready_vs_write: rx_ready=%b wr_en=%b", rx_ready_o, wr_en_o);
            end
            if (wr_en_o) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_write: addr %h data %h, expected none", wr_addr_o, wr_data_o);
                end else begin
                    logic [39:0] e;
                    e = exp_q.pop_front();
                    if ({wr_addr_o, wr_data_o} !== e) begin
                        fails++;
                        $display("FAIL write: got addr %h data %h, expected addr %h data %h",
                                 wr_addr_o, wr_data_o, e[39:32], e[31:0]);
                    end
                end
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic send(input logic [7:0] b, input bit hold);
        bit rdy;
        bit got;
        int g;
        rx_data  = b;
        rx_valid = 1'b1;
        got = 1'b0;
        g   = 0;
        while (!got && g < 20) begin
            rdy = rx_ready_o;
            @(negedge clk);
            g++;
            if (rdy) got = 1'b1;
        end
        if (!got) chk("send_timeout", 32'd0, 32'd1);
        if (!hold) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    // Sends SYNC, C, data_q and a checksum; chk_ovr < 0 means the correct XOR.
    task automatic load_image(input int c, input bit hold, input int chk_ovr);
        logic [7:0] x;
        logic [7:0] a;
        x = 8'h00;
        for (int w = 0; w <= c; w++) begin
            a = 8'(w);
            exp_q.push_back({a, data_q[4*w+3], data_q[4*w+2], data_q[4*w+1], data_q[4*w]});
        end
        foreach (data_q[i]) x ^= data_q[i];
        ready_low_cnt = 0;
        send(8'h55, hold);
        send(8'(c), hold);
        foreach (data_q[i]) send(data_q[i], hold);
        send((chk_ovr < 0) ? x : 8'(chk_ovr), 1'b0);
        chk("writes_outstanding", exp_q.size(), 0);
        chk("ready_low_cycles", ready_low_cnt, c + 1);
    endtask

    task automatic check_final(input string tag, input bit d, input bit e);
        chk({tag, "_done"}, done_o, d);
        chk({tag, "_err"}, err_o, e);
        chk({tag, "_cpu_rst_n"}, cpu_rst_no, d);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_wr_en"}, wr_en_o, 0);
        chk({tag, "_wr_addr"}, wr_addr_o, 0);
        chk({tag, "_wr_data"}, wr_data_o, 0);
        chk({tag, "_cpu_rst_n"}, cpu_rst_no, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, err_o, 0);
        chk({tag, "_rx_ready"}, rx_ready_o, 1);
    endtask

    initial begin
        logic [7:0] b;
        vecs[0] = '{c: 0,   hold: 0, bad: 0, garbage: 0, exp_done: 1, exp_err: 0};
        vecs[1] = '{c: 1,   hold: 1, bad: 0, garbage: 0, exp_done: 1, exp_err: 0};
        vecs[2] = '{c: 3,   hold: 0, bad: 1, garbage: 2, exp_done: 0, exp_err: 1};
        vecs[3] = '{c: 255, hold: 0, bad: 0, garbage: 0, exp_done: 1, exp_err: 0};
        vecs[4] = '{c: 7,   hold: 1, bad: 1, garbage: 0, exp_done: 0, exp_err: 1};
        vecs[5] = '{c: 15,  hold: 0, bad: 0, garbage: 3, exp_done: 1, exp_err: 0};

        rst_n    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single word, wrong checksum.
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00};
        load_image(0, 1'b0, 8'hA5);
        check_final("err_img", 1'b0, 1'b1);

        // Two words, correct checksum; released the cycle after the checksum byte.
        data_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        load_image(1, 1'b0, -1);
        check_final("two_word", 1'b1, 1'b0);

        // Garbage before SYNC from IDLE, then a normal load.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h00, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h12, 1'b0);
        chk("garbage_busy", busy_o, 0);
        chk("garbage_done", done_o, 0);
        data_q = '{8'h55, 8'h55, 8'h01, 8'h02};
        load_image(0, 1'b0, -1);
        check_final("after_garbage", 1'b1, 1'b0);

        for (int v = 0; v < 6; v++) begin
            for (int g = 0; g < vecs[v].garbage; g++) begin
                b = 8'($urandom_range(0, 255));
                if (b == 8'h55) b = 8'h56;
                send(b, 1'b0);
                chk("vec_garbage_busy", busy_o, 0);
            end
            data_q.delete();
            for (int i = 0; i < 4 * (vecs[v].c + 1); i++) data_q.push_back(8'($urandom_range(0, 255)));
            if (vecs[v].bad) begin
                logic [7:0] x;
                x = 8'h00;
                foreach (data_q[i]) x ^= data_q[i];
                load_image(vecs[v].c, vecs[v].hold, int'(x ^ 8'($urandom_range(1, 255))));
            end else begin
                load_image(vecs[v].c, vecs[v].hold, -1);
            end
            check_final($sformatf("vec%0d", v), vecs[v].exp_done, vecs[v].exp_err);
        end

        // Reset in the middle of DATA: first word already written, then abort.
        send(8'h55, 1'b0);
        send(8'h03, 1'b0);
        exp_q.push_back({8'h00, 32'hDDCCBBAA});
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        chk("mid_busy", busy_o, 1);
        chk("mid_writes", exp_q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        send(8'h33, 1'b0);
        send(8'h44, 1'b0);
        chk("post_reset_busy", busy_o, 0);

        // SYNC in DONE restarts and holds the core in reset again.
        data_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        load_image(0, 1'b0, -1);
        check_final("pre_restart", 1'b1, 1'b0);
        send(8'h55, 1'b0);
        chk("restart_done", done_o, 0);
        chk("restart_cpu_rst_n", cpu_rst_no, 0);
        chk("restart_busy", busy_o, 1);
        rst_n = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
